// File: rtl/dual_port_block_ram_pkg.sv
// Shared hit-storage parameters: word widths and row-index widths for the three
// memories built from dual_port_block_ram, plus a small address-range helper.
package dual_port_block_ram_pkg;

  localparam int SSIDBITS         = 8;
  localparam int COLINDEXBITS_HNM = 5;
  localparam int NCOLS_HNM        = 2 ** COLINDEXBITS_HNM;
  localparam int ROWINDEXBITS_HNM = SSIDBITS - COLINDEXBITS_HNM;
  localparam int NROWS_HNM        = 2 ** ROWINDEXBITS_HNM;

  localparam int HITINFOBITS      = 32;
  localparam int ROWINDEXBITS_HIM = 10;
  localparam int NCOLS_HIM        = HITINFOBITS;

  // Hits-count word: hit count in the low bits, HIM base address above it.
  localparam int HITCOUNTBITS     = 4;
  localparam int ROWINDEXBITS_HCM = SSIDBITS;
  localparam int NCOLS_HCM        = HITCOUNTBITS + ROWINDEXBITS_HIM;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/dual_port_block_ram.sv
// True dual-port synchronous RAM on one clock: write-first on each port, old data
// on cross-port read-during-write, port A wins a same-address double write.
module dual_port_block_ram
  import dual_port_block_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                  a_ok_s;
  logic                  b_ok_s;
  logic                  we_a_s;
  logic                  we_b_s;
  logic [DATA_WIDTH-1:0] rd_a_s;
  logic [DATA_WIDTH-1:0] rd_b_s;
  logic [DATA_WIDTH-1:0] douta_d;
  logic [DATA_WIDTH-1:0] douta_q;
  logic [DATA_WIDTH-1:0] doutb_d;
  logic [DATA_WIDTH-1:0] doutb_q;

  // Port A: range check, write strobe and next read-data (write-first).
  always_comb begin
    a_ok_s  = addr_in_range(32'(addra), DEPTH);
    rd_a_s  = a_ok_s ? mem_q[addra] : '0;
    we_a_s  = ena & wea & a_ok_s;
    douta_d = douta_q;
    if (ena) begin
      if (wea) begin
        douta_d = a_ok_s ? dina : '0;
      end else begin
        douta_d = rd_a_s;
      end
    end else begin
      douta_d = douta_q;
    end
  end

  // Port B: mirror of port A.
  always_comb begin
    b_ok_s  = addr_in_range(32'(addrb), DEPTH);
    rd_b_s  = b_ok_s ? mem_q[addrb] : '0;
    we_b_s  = enb & web & b_ok_s;
    doutb_d = doutb_q;
    if (enb) begin
      if (web) begin
        doutb_d = b_ok_s ? dinb : '0;
      end else begin
        doutb_d = rd_b_s;
      end
    end else begin
      doutb_d = doutb_q;
    end
  end

  // Storage array; A is written last so it wins an address collision.
  always_ff @(posedge clock) begin
    if (resetN) begin
      if (we_b_s) begin
        mem_q[addrb] <= dinb;
      end
      if (we_a_s) begin
        mem_q[addra] <= dina;
      end
    end
  end

  // Read-data registers; reset clears outputs only, never the array.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Directed bench for dual_port_block_ram with hand-computed expectations.
module tb_dual_port_block_ram;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DP = 1024;

  logic          clock;
  logic          resetN;
  logic          ena, wea, enb, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [DW-1:0] douta, doutb;

  int n_cmp;
  int n_err;

  dual_port_block_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clock (clock),
    .resetN(resetN),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic port_a(input logic en, input logic we, input int addr, input logic [DW-1:0] d);
    ena = en; wea = we; addra = AW'(addr); dina = d;
  endtask

  task automatic port_b(input logic en, input logic we, input int addr, input logic [DW-1:0] d);
    enb = en; web = we; addrb = AW'(addr); dinb = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetN = 1'b0;
    port_a(1'b0, 1'b0, 0, 32'h0);
    port_b(1'b0, 1'b0, 0, 32'h0);
    repeat (3) tick();
    check("reset_douta", douta, 32'h0);
    check("reset_doutb", doutb, 32'h0);

    resetN = 1'b1;
    tick();
    check("idle_douta", douta, 32'h0);
    check("idle_doutb", doutb, 32'h0);

    // Basic write via A, read via B
    port_a(1'b1, 1'b1, 3, 32'h0000_00A5);
    tick();
    check("wf_a_addr3", douta, 32'h0000_00A5);
    port_a(1'b0, 1'b0, 0, 32'h0);
    port_b(1'b1, 1'b0, 3, 32'h0);
    tick();
    check("rd_b_addr3", doutb, 32'h0000_00A5);
    check("hold_a", douta, 32'h0000_00A5);

    // Write-first on A, cross-port old data on B
    port_a(1'b1, 1'b1, 7, 32'h0000_1234);
    port_b(1'b1, 1'b0, 7, 32'h0);
    tick();
    check("wf_a_addr7", douta, 32'h0000_1234);
    check("xport_old_b", doutb, 32'h0000_0000);
    port_a(1'b0, 1'b0, 0, 32'h0);
    tick();
    check("xport_new_b", doutb, 32'h0000_1234);
    check("hold_a2", douta, 32'h0000_1234);

    // Same-address double write
    port_a(1'b1, 1'b1, 5, 32'h0000_0011);
    port_b(1'b1, 1'b1, 5, 32'h0000_0022);
    tick();
    check("coll_douta", douta, 32'h0000_0011);
    check("coll_doutb", doutb, 32'h0000_0022);
    port_a(1'b1, 1'b0, 5, 32'h0);
    port_b(1'b1, 1'b0, 5, 32'h0);
    tick();
    check("coll_rd_a", douta, 32'h0000_0011);
    check("coll_rd_b", doutb, 32'h0000_0011);

    // Enable gating
    port_b(1'b0, 1'b0, 0, 32'h0);
    port_a(1'b1, 1'b1, 2, 32'h0000_0055);
    tick();
    check("pre_addr2", douta, 32'h0000_0055);
    port_a(1'b0, 1'b1, 2, 32'h0000_00FF);
    tick();
    check("gated_hold_a", douta, 32'h0000_0055);
    port_a(1'b1, 1'b0, 2, 32'h0);
    tick();
    check("gated_addr2", douta, 32'h0000_0055);

    // Asynchronous reset mid-cycle, memory retained
    port_a(1'b1, 1'b1, 9, 32'h0000_003C);
    port_b(1'b1, 1'b0, 7, 32'h0);
    tick();
    check("pre_addr9", douta, 32'h0000_003C);
    check("pre_b_addr7", doutb, 32'h0000_1234);
    #3;
    resetN = 1'b0;
    #1;
    check("async_rst_a", douta, 32'h0);
    check("async_rst_b", doutb, 32'h0);
    port_a(1'b1, 1'b1, 9, 32'h0000_DEAD);
    port_b(1'b1, 1'b1, 7, 32'h0000_BEEF);
    tick();
    check("rst_held_a", douta, 32'h0);
    check("rst_held_b", doutb, 32'h0);
    #3;
    resetN = 1'b1;
    port_a(1'b1, 1'b0, 9, 32'h0);
    port_b(1'b0, 1'b0, 0, 32'h0);
    tick();
    check("post_rst_addr9", douta, 32'h0000_003C);
    check("post_rst_b_zero", doutb, 32'h0);
    port_a(1'b0, 1'b0, 0, 32'h0);
    port_b(1'b1, 1'b0, 7, 32'h0);
    tick();
    check("post_rst_addr7", doutb, 32'h0000_1234);

    // Full sweep: two words per cycle, then read everything back
    for (int i = 0; i < DP / 2; i++) begin
      port_a(1'b1, 1'b1, i, DW'(i));
      port_b(1'b1, 1'b1, DP - 1 - i, DW'(DP - 1 - i));
      tick();
    end
    check("sweep_last_a", douta, DW'(DP / 2 - 1));
    check("sweep_last_b", doutb, DW'(DP / 2));
    for (int i = 0; i < DP / 2; i++) begin
      port_a(1'b1, 1'b0, i, 32'h0);
      port_b(1'b1, 1'b0, DP - 1 - i, 32'h0);
      tick();
      check("sweep_rd_a", douta, DW'(i));
      check("sweep_rd_b", doutb, DW'(DP - 1 - i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
